// File: rtl/wb_slave_mux_n_if.sv
// Wishbone classic master-side port of the slave fan-out (user-area bus).
interface wb_slave_mux_n_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_slave_mux_n.sv
// Wishbone classic fan-out to N slaves: base/mask decode, registered request,
// watchdog timeout, error completion and sticky error status.
//
// state | meaning
// IDLE  | waiting for a master strobe; decodes address
// FWD   | request forwarded to latched slave; timer running
// ERR   | decode miss; load error pattern and status
// RESP  | one-cycle ack to master
module wb_slave_mux_n #(
    parameter int                      N_SLAVES       = 4,
    parameter logic [N_SLAVES*32-1:0]  BASE_ADDRS     = {32'h3000_3000, 32'h3000_2000,
                                                         32'h3000_1000, 32'h3000_0000},
    parameter logic [N_SLAVES*32-1:0]  ADDR_MASKS     = {4{32'hFFFF_F000}},
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    wb_slave_mux_n_if.slave          wb,
    output logic [N_SLAVES-1:0]      s_cyc_o,
    output logic [N_SLAVES-1:0]      s_stb_o,
    output logic                     s_we_o,
    output logic [3:0]               s_sel_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [N_SLAVES*32-1:0]   s_dat_i,
    input  logic [N_SLAVES-1:0]      s_ack_i,
    input  logic                     err_clr_i,
    output logic                     err_o,
    output logic                     err_timeout_o,
    output logic [2:0]               err_slave_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_ERR, ST_RESP} state_t;

    state_t              state, state_nxt;
    logic [TW-1:0]       timer;
    logic [2:0]          sel_idx;
    logic [N_SLAVES-1:0] strb_q;
    logic [31:0]         dat_q;

    logic                dec_hit;
    logic [2:0]          dec_idx;
    logic [N_SLAVES-1:0] dec_oh;
    logic                ack_sel;
    logic [31:0]         dat_sel;

    logic ld_req, clr_strb, cap_ack, cap_to, cap_miss;

    assign s_cyc_o      = strb_q;
    assign s_stb_o      = strb_q;
    assign wb.wbs_dat_o = dat_q;
    assign wb.wbs_ack_o = (state == ST_RESP);

    // Address decode; iterate downwards so the lowest matching index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = 3'd0;
        dec_oh  = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((wb.wbs_adr_i & ADDR_MASKS[32*i +: 32]) == BASE_ADDRS[32*i +: 32]) begin
                dec_hit = 1'b1;
                dec_idx = 3'(i);
            end
        end
        for (int i = 0; i < N_SLAVES; i++) begin
            dec_oh[i] = dec_hit && (dec_idx == 3'(i));
        end
    end

    // Response mux from the latched slave only; other slaves' acks are ignored.
    always_comb begin
        ack_sel = 1'b0;
        dat_sel = 32'h0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_idx == 3'(i)) begin
                ack_sel = s_ack_i[i];
                dat_sel = s_dat_i[32*i +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    // Next-state and datapath control; master abort outranks a same-cycle ack.
    always_comb begin
        state_nxt = state;
        ld_req    = 1'b0;
        clr_strb  = 1'b0;
        cap_ack   = 1'b0;
        cap_to    = 1'b0;
        cap_miss  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
                    if (dec_hit) begin
                        ld_req    = 1'b1;
                        state_nxt = ST_FWD;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_FWD: begin
                if (!wb.wbs_cyc_i) begin
                    clr_strb  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (ack_sel) begin
                    clr_strb  = 1'b1;
                    cap_ack   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (timer == T_LAST) begin
                    clr_strb  = 1'b1;
                    cap_to    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_ERR: begin
                cap_miss  = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request registers, strobes, timer and read-data capture.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            strb_q  <= '0;
            sel_idx <= 3'd0;
            timer   <= '0;
            s_we_o  <= 1'b0;
            s_sel_o <= 4'h0;
            s_adr_o <= 32'h0;
            s_dat_o <= 32'h0;
            dat_q   <= 32'h0;
        end else begin
            if (ld_req) begin
                strb_q  <= dec_oh;
                sel_idx <= dec_idx;
                timer   <= '0;
                s_we_o  <= wb.wbs_we_i;
                s_sel_o <= wb.wbs_sel_i;
                s_adr_o <= wb.wbs_adr_i;
                s_dat_o <= wb.wbs_dat_i;
            end else begin
                if (clr_strb) strb_q <= '0;
                if (state == ST_FWD && timer != T_MAX) timer <= timer + 1'b1;
            end
            if (cap_ack)           dat_q <= dat_sel;
            if (cap_to || cap_miss) dat_q <= ERR_DATA;
        end
    end

    // Sticky status; a new error event beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            err_o         <= 1'b0;
            err_timeout_o <= 1'b0;
            err_slave_o   <= 3'd0;
        end else if (cap_to) begin
            err_o         <= 1'b1;
            err_timeout_o <= 1'b1;
            err_slave_o   <= sel_idx;
        end else if (cap_miss) begin
            err_o         <= 1'b1;
            err_timeout_o <= 1'b0;
            err_slave_o   <= 3'd0;
        end else if (err_clr_i) begin
            err_o         <= 1'b0;
            err_timeout_o <= 1'b0;
            err_slave_o   <= 3'd0;
        end
    end

endmodule

// File: tb/tb_wb_slave_mux_n.sv
// Directed bench for wb_slave_mux_n with TIMEOUT_CYCLES=8.
module tb_wb_slave_mux_n;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_n_i = 1'b0;
    logic [3:0]   s_cyc_o, s_stb_o;
    logic         s_we_o;
    logic [3:0]   s_sel_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [127:0] s_dat_i = '0;
    logic [3:0]   s_ack_i = '0;
    logic         err_clr_i = 1'b0;
    logic         err_o, err_timeout_o;
    logic [2:0]   err_slave_o;

    int checks = 0;
    int failures = 0;

    wb_slave_mux_n_if wb_bus ();

    wb_slave_mux_n #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_n_i    (wb_rst_n_i),
        .wb            (wb_bus),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_we_o        (s_we_o),
        .s_sel_o       (s_sel_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_dat_i       (s_dat_i),
        .s_ack_i       (s_ack_i),
        .err_clr_i     (err_clr_i),
        .err_o         (err_o),
        .err_timeout_o (err_timeout_o),
        .err_slave_o   (err_slave_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic master_req(input logic we, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel);
        wb_bus.wbs_cyc_i = 1'b1;
        wb_bus.wbs_stb_i = 1'b1;
        wb_bus.wbs_we_i  = we;
        wb_bus.wbs_adr_i = adr;
        wb_bus.wbs_dat_i = dat;
        wb_bus.wbs_sel_i = sel;
    endtask

    task automatic master_idle();
        wb_bus.wbs_cyc_i = 1'b0;
        wb_bus.wbs_stb_i = 1'b0;
        wb_bus.wbs_we_i  = 1'b0;
    endtask

    initial begin
        master_idle();
        wb_bus.wbs_adr_i = '0;
        wb_bus.wbs_dat_i = '0;
        wb_bus.wbs_sel_i = '0;
        #2;
        check_val("rst_ack", 32'(wb_bus.wbs_ack_o), 32'd0);
        check_val("rst_dat", wb_bus.wbs_dat_o, 32'h0);
        check_val("rst_stb", 32'(s_stb_o), 32'h0);
        check_val("rst_err", 32'(err_o), 32'd0);
        @(posedge wb_clk_i);
        #1 wb_rst_n_i = 1'b1;
        tick();

        // read slave 1, slave acks in its third strobe cycle
        master_req(1'b0, 32'h3000_1004, 32'h0, 4'hF);
        tick();
        check_val("rd_stb_c1", 32'(s_stb_o), 32'h2);
        check_val("rd_adr", s_adr_o, 32'h3000_1004);
        tick();
        check_val("rd_stb_c2", 32'(s_stb_o), 32'h2);
        tick();
        check_val("rd_stb_c3", 32'(s_stb_o), 32'h2);
        check_val("rd_noack_early", 32'(wb_bus.wbs_ack_o), 32'd0);
        s_ack_i = 4'b0010;
        s_dat_i[63:32] = 32'h1234_5678;
        tick();
        s_ack_i = 4'b0000;
        master_idle();
        check_val("rd_ack", 32'(wb_bus.wbs_ack_o), 32'd1);
        check_val("rd_dat", wb_bus.wbs_dat_o, 32'h1234_5678);
        check_val("rd_stb_off", 32'(s_stb_o), 32'h0);
        check_val("rd_err", 32'(err_o), 32'd0);
        tick();
        check_val("rd_ack_pulse", 32'(wb_bus.wbs_ack_o), 32'd0);
        check_val("rd_dat_hold", wb_bus.wbs_dat_o, 32'h1234_5678);

        // write slave 0, combinational ack in first strobe cycle
        master_req(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'b0011);
        tick();
        check_val("wr_cyc", 32'(s_cyc_o), 32'h1);
        check_val("wr_adr", s_adr_o, 32'h3000_0010);
        check_val("wr_dat", s_dat_o, 32'hA5A5_0001);
        check_val("wr_sel", 32'(s_sel_o), 32'h3);
        check_val("wr_we", 32'(s_we_o), 32'd1);
        s_ack_i = 4'b0001;
        tick();
        s_ack_i = 4'b0000;
        master_idle();
        check_val("wr_ack_t2", 32'(wb_bus.wbs_ack_o), 32'd1);
        tick();
        check_val("wr_single_ack", 32'(wb_bus.wbs_ack_o), 32'd0);

        // decode miss
        master_req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        tick();
        check_val("miss_stb", 32'(s_stb_o), 32'h0);
        check_val("miss_noack_t1", 32'(wb_bus.wbs_ack_o), 32'd0);
        tick();
        master_idle();
        check_val("miss_ack_t2", 32'(wb_bus.wbs_ack_o), 32'd1);
        check_val("miss_dat", wb_bus.wbs_dat_o, 32'hDEAD_BEEF);
        check_val("miss_err", 32'(err_o), 32'd1);
        check_val("miss_to", 32'(err_timeout_o), 32'd0);
        check_val("miss_slave", 32'(err_slave_o), 32'd0);
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check_val("clr_err", 32'(err_o), 32'd0);

        // timeout on slave 2; ack from slave 0 meanwhile must be ignored
        master_req(1'b0, 32'h3000_2000, 32'h0, 4'hF);
        tick();
        s_ack_i = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("to_stb_%0d", k), 32'(s_stb_o), 32'h4);
            tick();
        end
        s_ack_i = 4'b0000;
        check_val("to_stb_off", 32'(s_stb_o), 32'h0);
        check_val("to_ack", 32'(wb_bus.wbs_ack_o), 32'd1);
        check_val("to_dat", wb_bus.wbs_dat_o, 32'hDEAD_BEEF);
        check_val("to_err", 32'(err_o), 32'd1);
        check_val("to_flag", 32'(err_timeout_o), 32'd1);
        check_val("to_slave", 32'(err_slave_o), 32'd2);
        master_idle();
        s_ack_i = 4'b0100;
        s_dat_i[95:64] = 32'h5555_AAAA;
        tick();
        check_val("late_noack", 32'(wb_bus.wbs_ack_o), 32'd0);
        check_val("late_dat", wb_bus.wbs_dat_o, 32'hDEAD_BEEF);
        tick();
        s_ack_i = 4'b0000;
        check_val("late_noack2", 32'(wb_bus.wbs_ack_o), 32'd0);
        check_val("late_stb", 32'(s_stb_o), 32'h0);

        // clear, then new miss error coinciding with a clear
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check_val("clr2_err", 32'(err_o), 32'd0);
        master_req(1'b0, 32'h5000_0000, 32'h0, 4'hF);
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        master_idle();
        check_val("setwin_err", 32'(err_o), 32'd1);
        check_val("setwin_to", 32'(err_timeout_o), 32'd0);
        check_val("setwin_ack", 32'(wb_bus.wbs_ack_o), 32'd1);
        tick();

        // master abort in FWD
        master_req(1'b0, 32'h3000_3008, 32'h0, 4'hF);
        tick();
        check_val("ab_stb", 32'(s_stb_o), 32'h8);
        master_idle();
        tick();
        check_val("ab_stb_off", 32'(s_stb_o), 32'h0);
        check_val("ab_noack", 32'(wb_bus.wbs_ack_o), 32'd0);
        tick();
        check_val("ab_noack2", 32'(wb_bus.wbs_ack_o), 32'd0);

        // reset mid-FWD
        master_req(1'b0, 32'h3000_1000, 32'h0, 4'hF);
        tick();
        check_val("rs_stb_pre", 32'(s_stb_o), 32'h2);
        #1 wb_rst_n_i = 1'b0;
        #1;
        check_val("rs_stb", 32'(s_stb_o), 32'h0);
        check_val("rs_cyc", 32'(s_cyc_o), 32'h0);
        check_val("rs_adr", s_adr_o, 32'h0);
        check_val("rs_err", 32'(err_o), 32'd0);
        check_val("rs_dat", wb_bus.wbs_dat_o, 32'h0);
        master_idle();
        tick();
        wb_rst_n_i = 1'b1;
        tick();
        check_val("rs_noack", 32'(wb_bus.wbs_ack_o), 32'd0);

        // post-reset read to slave 3
        master_req(1'b0, 32'h3000_3004, 32'h0, 4'hF);
        tick();
        check_val("pr_stb", 32'(s_stb_o), 32'h8);
        s_ack_i = 4'b1000;
        s_dat_i[127:96] = 32'hCAFE_0003;
        tick();
        s_ack_i = 4'b0000;
        master_idle();
        check_val("pr_ack", 32'(wb_bus.wbs_ack_o), 32'd1);
        check_val("pr_dat", wb_bus.wbs_dat_o, 32'hCAFE_0003);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_slave_mux_n.md
Name: wb_slave_mux_n

Overview:
Parametrised Wishbone classic slave-side fan-out that sits between the user-area Wishbone port and N user-project slaves, such as the HyperRAM controller and its config register bank. It decodes the address against per-slave base/mask pairs and forwards one transaction at a time with a registered request. It returns the slave response and enforces a watchdog timeout. Unmapped or stalled accesses complete with an error pattern and a sticky status record.

Parameters:
N_SLAVES, 4, number of downstream slaves (1..8)
BASE_ADDRS, {32'h3000_3000, 32'h3000_2000, 32'h3000_1000, 32'h3000_0000}, packed N_SLAVES*32; slave i base at bits [32i+31:32i]
ADDR_MASKS, {4{32'hFFFF_F000}}, packed N_SLAVES*32; slave i matches when (adr & mask_i) == base_i
TIMEOUT_CYCLES, 255, max cycles in FWD before forced error completion (>=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on decode miss or timeout

Ports:
wb_clk_i  in  1  system clock
wb_rst_n_i  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  master cycle
wbs_stb_i  in  1  master strobe
wbs_we_i  in  1  master write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  ack to master, one-cycle pulse
wbs_dat_o  out  32  read data to master
s_cyc_o  out  N_SLAVES  per-slave cycle, one-hot or zero
s_stb_o  out  N_SLAVES  per-slave strobe, one-hot or zero
s_we_o  out  1  shared registered write enable
s_sel_o  out  4  shared registered byte selects
s_adr_o  out  32  shared registered address
s_dat_o  out  32  shared registered write data
s_dat_i  in  N_SLAVES*32  per-slave read data
s_ack_i  in  N_SLAVES  per-slave ack
err_clr_i  in  1  clears sticky status
err_o  out  1  sticky: a miss or timeout has occurred
err_timeout_o  out  1  sticky: last error was a timeout (0 = decode miss)
err_slave_o  out  3  slave index of last timeout; 0 on decode miss

Behaviour:
- Reset (async, wb_rst_n_i=0): all outputs 0, state IDLE, timer 0. Reset mid-transaction drops s_cyc_o/s_stb_o immediately. No ack is generated.
- States: IDLE, FWD, ERR, RESP.
- IDLE, wbs_cyc_i & wbs_stb_i high:
  - Decode; the lowest index wins on overlapping matches.
  - Match i: register we/sel/adr/dat into s_*_o, set bit i of s_cyc_o and s_stb_o, clear timer, go to FWD.
  - No match: go to ERR.
- FWD:
  - Hold strobes and registered request stable; increment timer each cycle.
  - s_ack_i[i] high (i = latched index only; acks from other slaves are ignored): clear s_cyc_o/s_stb_o, capture s_dat_i[i] into wbs_dat_o, go to RESP.
  - Timer == TIMEOUT_CYCLES-1 with no ack: clear strobes, load ERR_DATA into wbs_dat_o, set err_o=1, err_timeout_o=1, err_slave_o=i, go to RESP.
  - wbs_cyc_i low (master abort): clear strobes, go to IDLE, no ack.
- ERR: one cycle. Load ERR_DATA into wbs_dat_o, set err_o=1, err_timeout_o=0, err_slave_o=0, go to RESP.
- RESP: wbs_ack_o=1 for exactly this cycle, then go to IDLE. wbs_dat_o holds its value until the next capture.
- Writes get the same ack path; on an error, wbs_dat_o=ERR_DATA is don't-care for writes.
- Latency:
  - Slave acking combinationally in its first strobe cycle: master strobe at T0, s_stb at T1, wbs_ack at T2.
  - In general, ack to master arrives one cycle after the slave ack.
  - Decode miss: ack at T2.
- Late slave ack after timeout or abort is ignored; in IDLE, s_ack_i has no effect.
- Status:
  - err_clr_i clears err_o, err_timeout_o and err_slave_o.
  - A set event in the same cycle as err_clr_i wins.
- Timer width is clog2(TIMEOUT_CYCLES+1) and saturates, never wraps.

Test Plan:
- Read slave 1: adr=0x3000_1004, slave 1 acks after 3 cycles with 0x1234_5678 -> s_stb_o=4'b0010 for 3 cycles, wbs_ack_o pulses 1 cycle after the slave ack, wbs_dat_o=0x1234_5678, err_o=0.
- Write slave 0: adr=0x3000_0010, dat=0xA5A5_0001, sel=4'b0011 -> s_adr_o/s_dat_o/s_sel_o/s_we_o registered exactly; only s_cyc_o[0] set; single ack.
- Decode miss: adr=0x4000_0000 -> no s_stb_o activity, wbs_ack_o at T2, wbs_dat_o=0xDEAD_BEEF, err_o=1, err_timeout_o=0.
- Timeout: slave 2 never acks, TIMEOUT_CYCLES=8 -> strobes drop after 8 cycles, ack with 0xDEAD_BEEF, err_timeout_o=1, err_slave_o=2; a late s_ack_i[2] is ignored; err_clr_i and a new error in the same cycle leave err_o=1.
- Abort and reset: master drops cyc in FWD -> slave strobes cleared next edge, no ack; wb_rst_n_i asserted mid-FWD -> all outputs 0 immediately; a post-reset read to slave 3 succeeds.
